// File: rtl/clint_mh_pkg.sv
// rtl/clint_mh_pkg.sv - shared offsets, reset constants and address decode for clint_mh
package clint_mh_pkg;

    localparam logic [31:0] MSIP_BASE     = 32'h0000_0000;
    localparam logic [31:0] MTIMECMP_BASE = 32'h0000_4000;
    localparam logic [31:0] MTIME_OFF     = 32'h0000_BFF8;

    localparam logic [63:0] MTIME_RST    = 64'h0000_0000_0000_0000;
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        SEL_NONE     = 2'd0,
        SEL_MSIP     = 2'd1,
        SEL_MTIMECMP = 2'd2,
        SEL_MTIME    = 2'd3
    } sel_e;

    typedef struct packed {
        sel_e       sel;
        logic [3:0] hart;
        logic       hi;
    } dec_t;

    // Hart number from an offset relative to a region base; shift is log2 of the stride.
    function automatic logic [3:0] hart_idx(input logic [31:0] rel, input int shift);
        return 4'(rel >> shift);
    endfunction

    // Classify a byte offset; anything not matched stays SEL_NONE and becomes a bus error.
    function automatic dec_t clint_decode(input logic [31:0] off, input int nhart, input int data_w);
        dec_t        d;
        logic [31:0] rel_msip;
        logic [31:0] rel_cmp;
        logic        half_ok;
        d.sel    = SEL_NONE;
        d.hart   = 4'd0;
        d.hi     = (data_w == 32) && off[2];
        // On a 64-bit bus the +4 word of a 64-bit register is not addressable.
        half_ok  = (data_w == 32) || !off[2];
        // Subtracting the base lets one unsigned compare bound both ends of the region.
        rel_msip = off - MSIP_BASE;
        rel_cmp  = off - MTIMECMP_BASE;
        if (off[1:0] == 2'b00) begin
            if (rel_msip < 32'(4 * nhart)) begin
                d.sel  = SEL_MSIP;
                d.hart = hart_idx(rel_msip, 2);
                d.hi   = 1'b0;
            end else if ((rel_cmp < 32'(8 * nhart)) && half_ok) begin
                d.sel  = SEL_MTIMECMP;
                d.hart = hart_idx(rel_cmp, 3);
            end else if ((off[31:3] == MTIME_OFF[31:3]) && half_ok) begin
                d.sel  = SEL_MTIME;
            end
        end
        return d;
    endfunction

    // New value of a 64-bit register after a write; a 32-bit bus replaces only one half.
    function automatic logic [63:0] merge64(input logic [63:0] old, input logic [63:0] wd,
                                            input logic hi, input int data_w);
        if (data_w == 64) begin
            return wd;
        end
        if (hi) begin
            return {wd[31:0], old[31:0]};
        end
        return {old[63:32], wd[31:0]};
    endfunction

endpackage

// File: rtl/clint_mh_if.sv
// rtl/clint_mh_if.sv - MMIO request/response bundle between crossbar and clint_mh
interface clint_mh_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);
    logic              clint_req_i;
    logic              clint_we_i;
    logic [ADDR_W-1:0] clint_addr_i;
    logic [DATA_W-1:0] clint_wdata_i;
    logic              clint_rvalid_o;
    logic [DATA_W-1:0] clint_rdata_o;
    logic              clint_err_o;
    logic              clint_skip_o;

    modport master (
        output clint_req_i, clint_we_i, clint_addr_i, clint_wdata_i,
        input  clint_rvalid_o, clint_rdata_o, clint_err_o, clint_skip_o
    );

    modport slave (
        input  clint_req_i, clint_we_i, clint_addr_i, clint_wdata_i,
        output clint_rvalid_o, clint_rdata_o, clint_err_o, clint_skip_o
    );
endinterface

// File: rtl/clint_mh_prescaler.sv
// rtl/clint_mh_prescaler.sv - mtime prescaler: one tick every PRESC enabled clocks
module clint_mh_prescaler #(
    parameter int PRESC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Tick on the last count of the period; with PRESC=1 this is every enabled clock.
    assign tick_o = en_i && (cnt_q == CW'(PRESC - 1));

    // A write to mtime restarts the period so the written value lasts a full PRESC clocks.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/clint_mh.sv
// rtl/clint_mh.sv - multi-hart core-local interruptor with registered MMIO response
module clint_mh
    import clint_mh_pkg::*;
#(
    parameter int NHART  = 1,
    parameter int DATA_W = 64,
    parameter int PRESC  = 1,
    parameter int ADDR_W = 16
) (
    input  logic             clint_clk_i,
    input  logic             clint_rst_n_i,
    clint_mh_if.slave        bus,
    input  logic             clint_tick_en_i,
    output logic [NHART-1:0] clint_mtip_o,
    output logic [NHART-1:0] clint_msip_o
);
    logic [31:0]       off;
    dec_t              dec;
    logic              wr;
    logic              rd;
    logic [63:0]       wdata64;
    logic              mtime_we;
    logic              tick;

    logic [63:0]       mtime_q;
    logic [63:0]       mtime_d;
    logic [63:0]       cmp_all [NHART];
    logic [NHART-1:0]  sip_all;
    logic [NHART-1:0]  tip_all;

    logic [63:0]       rd_val;
    logic [63:0]       rd_sh;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    assign off      = 32'(bus.clint_addr_i);
    assign dec      = clint_decode(off, NHART, DATA_W);
    assign wr       = bus.clint_req_i &&  bus.clint_we_i && (dec.sel != SEL_NONE);
    assign rd       = bus.clint_req_i && !bus.clint_we_i && (dec.sel != SEL_NONE);
    assign wdata64  = 64'(bus.clint_wdata_i);
    assign mtime_we = wr && (dec.sel == SEL_MTIME);

    clint_mh_prescaler #(.PRESC(PRESC)) u_presc (
        .clk    (clint_clk_i),
        .rst_n  (clint_rst_n_i),
        .en_i   (clint_tick_en_i),
        .clr_i  (mtime_we),
        .tick_o (tick)
    );

    // mtime: a bus write beats the increment, and a half write applies no carry that cycle.
    always_comb begin
        mtime_d = mtime_q;
        if (mtime_we) begin
            mtime_d = merge64(mtime_q, wdata64, dec.hi, DATA_W);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // mtime register; wraps silently at 2^64.
    always_ff @(posedge clint_clk_i or negedge clint_rst_n_i) begin
        if (!clint_rst_n_i) begin
            mtime_q <= MTIME_RST;
        end else begin
            mtime_q <= mtime_d;
        end
    end

    for (genvar h = 0; h < NHART; h++) begin : g_hart
        logic [63:0] cmp_q, cmp_d;
        logic        sip_q, sip_d;
        logic        tip_q, tip_d;
        logic        cmp_we;
        logic        sip_we;

        assign cmp_we = wr && (dec.sel == SEL_MTIMECMP) && (dec.hart == 4'(h));
        assign sip_we = wr && (dec.sel == SEL_MSIP)     && (dec.hart == 4'(h));

        // Per-hart writes and the timer compare, evaluated on current register values.
        always_comb begin
            cmp_d = cmp_we ? merge64(cmp_q, wdata64, dec.hi, DATA_W) : cmp_q;
            sip_d = sip_we ? wdata64[0] : sip_q;
            tip_d = (mtime_q >= cmp_q);
        end

        // Per-hart registers.
        always_ff @(posedge clint_clk_i or negedge clint_rst_n_i) begin
            if (!clint_rst_n_i) begin
                cmp_q <= MTIMECMP_RST;
                sip_q <= 1'b0;
                tip_q <= 1'b0;
            end else begin
                cmp_q <= cmp_d;
                sip_q <= sip_d;
                tip_q <= tip_d;
            end
        end

        assign cmp_all[h] = cmp_q;
        assign sip_all[h] = sip_q;
        assign tip_all[h] = tip_q;
    end

    // Read mux over pre-update values, then half select for a 32-bit bus.
    always_comb begin
        rd_val = 64'd0;
        case (dec.sel)
            SEL_MTIME: rd_val = mtime_q;
            SEL_MSIP: begin
                for (int h = 0; h < NHART; h++) begin
                    if (dec.hart == 4'(h)) rd_val = {63'd0, sip_all[h]};
                end
            end
            SEL_MTIMECMP: begin
                for (int h = 0; h < NHART; h++) begin
                    if (dec.hart == 4'(h)) rd_val = cmp_all[h];
                end
            end
            default: rd_val = 64'd0;
        endcase
        rd_sh    = dec.hi ? {32'd0, rd_val[63:32]} : rd_val;
        rvalid_d = bus.clint_req_i;
        err_d    = bus.clint_req_i && (dec.sel == SEL_NONE);
        rdata_d  = rd ? DATA_W'(rd_sh) : '0;
    end

    // One-cycle registered response; reset drops anything in flight.
    always_ff @(posedge clint_clk_i or negedge clint_rst_n_i) begin
        if (!clint_rst_n_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign bus.clint_rvalid_o = rvalid_q;
    assign bus.clint_rdata_o  = rdata_q;
    assign bus.clint_err_o    = err_q;
    assign bus.clint_skip_o   = rvalid_q;
    assign clint_mtip_o       = tip_all;
    assign clint_msip_o       = sip_all;
endmodule
